ram_port_scheduler: RTL and testbench

- Controller in front of the 128-bit dual-port unified RAM: one read/write port (A) and one read-only port (B), 19-bit byte address, unaligned access through internal byte rotation.
- Port A is shared round-robin between NUM_REQ requesters (core load/store units, DMA) over a valid/ready request and pulsed response interface.
- Port B is owned by a framebuffer scanout sequencer. It walks a 16-byte-stride region and streams words to the HDMI path through a credit-controlled FIFO.

---
 rtl/ram_sched_pkg.sv | 8 +
 rtl/ram_port_scheduler_if.sv | 16 +
 rtl/ram_sched_rr_arbiter.sv | 33 +++
 rtl/ram_port_scheduler.sv | 118 +++++++++++
 tb/tb_ram_port_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_sched_pkg.sv
// ram_sched_pkg: shared constants and state type for the RAM port scheduler
package ram_sched_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 128;
  localparam int BE_W = DATA_W / 8;
  localparam int LINE_BYTES = 16;
  typedef enum logic {IDLE, RUN} scan_state_t;
endpackage

// File: rtl/ram_port_scheduler_if.sv
// ram_port_scheduler_if: port-A requester bus (requests in, pulsed responses out)
interface ram_port_scheduler_if #(parameter int NUM_REQ = 4);
  import ram_sched_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0][BE_W-1:0] req_byte_enablers;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  modport master (output req_valid, req_write, req_address, req_data, req_byte_enablers,
                  input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, req_write, req_address, req_data, req_byte_enablers,
                 output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ram_sched_rr_arbiter.sv
// ram_sched_rr_arbiter: round-robin grant starting at a pointer that moves past each winner
module ram_sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  logic [IDX_W-1:0] ptr_q, ptr_d, j;
  // search upward from the pointer with wrap-around; first valid requester wins
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!any_o && valid_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
    grant_o = any_o ? NUM_REQ'(1) << idx_o : '0;
    ptr_d = !any_o ? ptr_q : (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + IDX_W'(1);
  end
  // pointer register
  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/ram_port_scheduler.sv
// ram_port_scheduler: shared round-robin port A plus framebuffer scanout on read-only port B
module ram_port_scheduler import ram_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int SCAN_FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  ram_port_scheduler_if.slave req,
  input  logic                scan_start,
  input  logic                scan_stop,
  input  logic [ADDR_W-1:0]   scan_base,
  input  logic [15:0]         scan_words,
  input  logic                scan_continuous,
  output logic                scan_valid,
  input  logic                scan_ready,
  output logic [DATA_W-1:0]   scan_data,
  output logic                scan_busy,
  output logic                scan_done,
  output logic [ADDR_W-1:0]   ram_address_a,
  output logic [DATA_W-1:0]   ram_data_in,
  output logic [BE_W-1:0]     ram_byte_enablers,
  output logic                ram_write_enable,
  input  logic [DATA_W-1:0]   ram_data_out_a,
  output logic [ADDR_W-1:0]   ram_address_b,
  input  logic [DATA_W-1:0]   ram_data_out_b
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PW = $clog2(SCAN_FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [NUM_REQ-1:0] grant, rsp_q;
  logic [IDX_W-1:0] g;
  logic any;
  ram_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock(clock), .reset(reset), .valid_i(req.req_valid),
    .grant_o(grant), .idx_o(g), .any_o(any)
  );
  assign req.req_ready = grant;
  assign ram_address_a = any ? req.req_address[g] : '0;
  assign ram_data_in = any ? req.req_data[g] : '0;
  assign ram_byte_enablers = any ? req.req_byte_enablers[g] : '0;
  assign ram_write_enable = any & req.req_write[g];
  // response pulse follows the grant by the one-cycle RAM latency
  always_ff @(posedge clock or negedge reset)
    if (!reset) rsp_q <= '0;
    else rsp_q <= grant;
  assign req.rsp_valid = rsp_q;
  assign req.rsp_data = |rsp_q ? ram_data_out_a : '0;
  scan_state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0] words_q, words_d, idx_q, idx_d;
  logic fin_q, fin_d, infl_q, issue, last, done, push, pop;
  logic [DATA_W-1:0] mem_q [SCAN_FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  assign issue = state_q == RUN && !fin_q && !scan_stop &&
                 (int'(cnt_q) + int'(infl_q)) < SCAN_FIFO_DEPTH;
  assign last = idx_q == words_q - 16'd1;
  assign done = state_q == RUN && fin_q && !infl_q && !scan_stop;
  assign push = infl_q && !scan_stop;
  assign pop = scan_valid && scan_ready;
  assign ram_address_b = issue ? base_q + (ADDR_W'(idx_q) << 4) : '0;
  assign scan_valid = cnt_q != '0;
  assign scan_data = scan_valid ? mem_q[rp_q] : '0;
  assign scan_busy = state_q == RUN;
  assign scan_done = done;
  // sequencer next state: stop wins, start only from IDLE, finish once the last read has returned
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    words_d = words_q;
    idx_d = idx_q;
    fin_d = fin_q;
    if (scan_stop) begin
      state_d = IDLE;
      fin_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (scan_start && scan_words != '0) begin
        state_d = RUN;
        base_d = scan_base;
        words_d = scan_words;
        idx_d = '0;
        fin_d = 1'b0;
      end
    end else begin
      if (issue) begin
        idx_d = last ? '0 : idx_q + 16'd1;
        fin_d = last && !scan_continuous;
      end
      if (done) state_d = IDLE;
    end
  end
  // sequencer and FIFO bookkeeping; stop flushes everything including the read in flight
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      base_q <= '0;
      words_q <= '0;
      idx_q <= '0;
      fin_q <= 1'b0;
      infl_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      words_q <= words_d;
      idx_q <= idx_d;
      fin_q <= fin_d;
      infl_q <= issue;
      wp_q <= scan_stop ? '0 : wp_q + PW'(push);
      rp_q <= scan_stop ? '0 : rp_q + PW'(pop);
      cnt_q <= scan_stop ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
  // FIFO storage captures port-B data one cycle after issue
  always_ff @(posedge clock)
    if (push) mem_q[wp_q] <= ram_data_out_b;
endmodule

// File: tb/tb_ram_port_scheduler.sv
// tb_ram_port_scheduler: directed vectors for port-A arbitration and scanout sequencing
module tb_ram_port_scheduler;
  import ram_sched_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  ram_port_scheduler_if #(.NUM_REQ(4)) bus ();
  logic scan_start, scan_stop, scan_continuous, scan_valid, scan_ready, scan_busy, scan_done;
  logic [ADDR_W-1:0] scan_base, ram_address_a, ram_address_b;
  logic [15:0] scan_words;
  logic [DATA_W-1:0] scan_data, ram_data_in, ram_data_out_a, ram_data_out_b;
  logic [BE_W-1:0] ram_byte_enablers;
  logic ram_write_enable;
  ram_port_scheduler #(.NUM_REQ(4), .SCAN_FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .req(bus),
    .scan_start(scan_start), .scan_stop(scan_stop), .scan_base(scan_base),
    .scan_words(scan_words), .scan_continuous(scan_continuous), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .scan_data(scan_data), .scan_busy(scan_busy), .scan_done(scan_done),
    .ram_address_a(ram_address_a), .ram_data_in(ram_data_in),
    .ram_byte_enablers(ram_byte_enablers), .ram_write_enable(ram_write_enable),
    .ram_data_out_a(ram_data_out_a), .ram_address_b(ram_address_b),
    .ram_data_out_b(ram_data_out_b)
  );
  function automatic logic [DATA_W-1:0] pat(input int w);
    return {4{32'hC0DE0000 | 32'(w)}};
  endfunction
  function automatic logic [DATA_W-1:0] exp_scan(input logic [ADDR_W-1:0] base, input int k);
    logic [ADDR_W-1:0] a;
    a = base + ADDR_W'(k * 16);
    return pat(int'(a[7:4]));
  endfunction
  // 16-word RAM model aliased on address bits 7:4, one-cycle read latency, old data on collision
  logic [DATA_W-1:0] mem [16];
  always @(posedge clock) begin
    if (!reset) begin
      for (int w = 0; w < 16; w++) mem[w] <= pat(w);
    end else if (ram_write_enable) begin
      for (int b = 0; b < BE_W; b++)
        if (ram_byte_enablers[b]) mem[ram_address_a[7:4]][b*8 +: 8] <= ram_data_in[b*8 +: 8];
    end
    ram_data_out_a <= mem[ram_address_a[7:4]];
    ram_data_out_b <= mem[ram_address_b[7:4]];
  end
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic scan_go(input logic [ADDR_W-1:0] base, input logic [15:0] words);
    @(negedge clock);
    scan_base = base;
    scan_words = words;
    scan_start = 1'b1;
    @(negedge clock);
    scan_start = 1'b0;
  endtask
  task automatic collect(input logic [ADDR_W-1:0] base, input int n, input int budget);
    int got = 0;
    int dn = 0;
    scan_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (scan_done) dn++;
      if (scan_valid && scan_ready) begin
        if (got < n) chk("scan_word", scan_data, exp_scan(base, got));
        got++;
      end
      if (got >= n && !scan_busy) break;
      @(negedge clock);
    end
    chk("scan_count", 128'(got), 128'(n));
    chk("scan_done_pulses", 128'(dn), 128'd1);
    chk("scan_busy_fell", 128'(scan_busy), 128'd0);
    scan_ready = 1'b0;
  endtask
  typedef struct {
    logic [3:0] v;
    logic [3:0] g;
  } vec_t;
  vec_t vt [12];
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] prev;
    logic [DATA_W-1:0] hi;
    int cnt [4];
    int lastg [4];
    int maxgap [4];
    int iss;
    vt[0] = '{4'b0101, 4'b0001};
    vt[1] = '{4'b0101, 4'b0100};
    vt[2] = '{4'b0101, 4'b0001};
    vt[3] = '{4'b0101, 4'b0100};
    vt[4] = '{4'b1111, 4'b1000};
    vt[5] = '{4'b1111, 4'b0001};
    vt[6] = '{4'b1111, 4'b0010};
    vt[7] = '{4'b0000, 4'b0000};
    vt[8] = '{4'b0011, 4'b0001};
    vt[9] = '{4'b1000, 4'b1000};
    vt[10] = '{4'b0110, 4'b0010};
    vt[11] = '{4'b0110, 4'b0100};
    bus.req_valid = '0;
    bus.req_write = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_address[i] = ADDR_W'((i + 1) * 16);
      bus.req_data[i] = '0;
      bus.req_byte_enablers[i] = '0;
    end
    scan_start = 1'b0;
    scan_stop = 1'b0;
    scan_base = '0;
    scan_words = '0;
    scan_continuous = 1'b0;
    scan_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 128'(bus.req_ready), 128'd0);
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("rst_rsp_data", bus.rsp_data, 128'd0);
    chk("rst_we", 128'(ram_write_enable), 128'd0);
    chk("rst_be", 128'(ram_byte_enablers), 128'd0);
    chk("rst_scan_valid", 128'(scan_valid), 128'd0);
    chk("rst_scan_busy", 128'(scan_busy), 128'd0);
    chk("rst_scan_done", 128'(scan_done), 128'd0);
    chk("rst_addr_b", 128'(ram_address_b), 128'd0);
    reset = 1'b1;
    prev = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("rsp_valid", 128'(bus.rsp_valid), 128'(prev));
      if (prev != '0) chk("rsp_data", bus.rsp_data, pat($clog2(prev) + 1));
      bus.req_valid = vt[k].v;
      #1;
      chk("grant", 128'(bus.req_ready), 128'(vt[k].g));
      prev = vt[k].g;
    end
    @(negedge clock);
    chk("rsp_valid_last", 128'(bus.rsp_valid), 128'(prev));
    chk("rsp_data_last", bus.rsp_data, pat($clog2(prev) + 1));
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      lastg[i] = -1;
      maxgap[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      bus.req_valid = 4'b1111;
      #1;
      chk("all_valid_onehot", 128'($onehot(bus.req_ready)), 128'd1);
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i]) begin
          cnt[i]++;
          if (c - lastg[i] > maxgap[i]) maxgap[i] = c - lastg[i];
          lastg[i] = c;
        end
    end
    @(negedge clock);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("fair_count", 128'(cnt[i]), 128'd4);
      chk("fair_gap_le4", 128'(maxgap[i] <= 4), 128'd1);
    end
    scan_go(19'h7FFF0, 16'd3);
    chk("scan_busy_run", 128'(scan_busy), 128'd1);
    chk("scan_addr0", 128'(ram_address_b), 128'h7FFF0);
    @(negedge clock);
    chk("scan_addr1_wrap", 128'(ram_address_b), 128'h00000);
    @(negedge clock);
    chk("scan_addr2", 128'(ram_address_b), 128'h00010);
    collect(19'h7FFF0, 3, 40);
    scan_go(19'h00100, 16'd8);
    iss = 0;
    for (int c = 0; c < 10; c++) begin
      if (ram_address_b != '0) iss++;
      @(negedge clock);
    end
    chk("stall_issue_count", 128'(iss), 128'd4);
    chk("stall_valid", 128'(scan_valid), 128'd1);
    chk("stall_busy", 128'(scan_busy), 128'd1);
    collect(19'h00100, 8, 80);
    scan_go(19'h00200, 16'd8);
    @(negedge clock);
    @(negedge clock);
    scan_stop = 1'b1;
    @(negedge clock);
    scan_stop = 1'b0;
    chk("stop_busy", 128'(scan_busy), 128'd0);
    chk("stop_valid", 128'(scan_valid), 128'd0);
    chk("stop_addr_b", 128'(ram_address_b), 128'd0);
    repeat (3) @(negedge clock);
    chk("stop_dropped", 128'(scan_valid), 128'd0);
    scan_go(19'h00240, 16'd2);
    chk("restart_addr", 128'(ram_address_b), 128'h00240);
    collect(19'h00240, 2, 30);
    @(negedge clock);
    bus.req_valid = 4'b0010;
    bus.req_write = 4'b0010;
    bus.req_address[1] = 19'h00003;
    bus.req_data[1] = 128'hDEADBEEF;
    bus.req_byte_enablers[1] = 16'h000F;
    #1;
    chk("wr_grant", 128'(bus.req_ready), 128'b0010);
    chk("wr_we", 128'(ram_write_enable), 128'd1);
    chk("wr_be", 128'(ram_byte_enablers), 128'h000F);
    @(negedge clock);
    chk("wr_ack", 128'(bus.rsp_valid), 128'b0010);
    bus.req_write = '0;
    #1;
    chk("rd_grant", 128'(bus.req_ready), 128'b0010);
    chk("rd_we", 128'(ram_write_enable), 128'd0);
    @(negedge clock);
    bus.req_valid = '0;
    hi = pat(0);
    chk("rd_rsp_valid", 128'(bus.rsp_valid), 128'b0010);
    chk("rd_low32", 128'(bus.rsp_data[31:0]), 128'hDEADBEEF);
    chk("rd_upper", 128'(bus.rsp_data[127:32]), 128'(hi[127:32]));
    @(negedge clock);
    chk("rsp_idle", 128'(bus.rsp_valid), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
